// File: rtl/hft_msg_pkg.sv
// Shared header layout and state/type encodings for the message deframer.
package hft_msg_pkg;

    localparam int unsigned TYPE_MSB = 15;
    localparam int unsigned TYPE_LSB = 12;
    localparam int unsigned LEN_MSB  = 11;
    localparam int unsigned LEN_LSB  = 0;
    localparam int unsigned TYPE_W   = TYPE_MSB - TYPE_LSB + 1;
    localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;

    typedef enum logic [TYPE_W-1:0] {
        MSG_NONE   = 4'h0,
        MSG_ADD    = 4'h1,
        MSG_MODIFY = 4'h2,
        MSG_CANCEL = 4'h3,
        MSG_EXEC   = 4'h4,
        MSG_TRADE  = 4'h5
    } msg_type_t;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } deframer_state_t;

endpackage

// File: rtl/fifo_msg_deframer_if.sv
// FIFO read port plus output payload stream of the deframer.
interface fifo_msg_deframer_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic              fifo_rd_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic [3:0]        out_type;

    modport master (
        input  fifo_rd_data, fifo_rd_empty, out_ready,
        output fifo_rd_en, out_valid, out_data, out_sop, out_eop, out_type
    );

    modport slave (
        output fifo_rd_data, fifo_rd_empty, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_sop, out_eop, out_type
    );

endinterface

// File: rtl/hft_stream_fifo_buf.sv
// Small synchronous FIFO with occupancy; head entry is presented directly from storage.
module hft_stream_fifo_buf #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   occ_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      occ_q;

    // Pointers wrap naturally, so DEPTH must be a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            occ_q <= occ_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_msg_deframer.sv
// Pops 16-bit words from the async FIFO read port and splits them into length-framed
// payload beats; malformed headers are counted and their frames dropped.
module fifo_msg_deframer
    import hft_msg_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    fifo_msg_deframer_if.master bus,
    output logic [CNT_W-1:0]    msg_cnt,
    output logic [CNT_W-1:0]    err_cnt
);
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = DATA_W + TYPE_W + 2;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    deframer_state_t   state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [TYPE_W-1:0] type_q;
    logic              first_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  msg_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;

    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    level_d;
    logic [ENT_W-1:0]  push_ent;
    logic [ENT_W-1:0]  head_ent;
    logic              push;
    logic              pop;
    logic              credit;
    logic              err_hit;
    logic [TYPE_W-1:0] hdr_type;
    logic [LEN_W-1:0]  hdr_len;

    assign hdr_type = bus.fifo_rd_data[TYPE_MSB:TYPE_LSB];
    assign hdr_len  = bus.fifo_rd_data[LEN_MSB:LEN_LSB];

    // Every in-flight word reserves a buffer slot, even if it turns out to be a header.
    assign pop     = bus.out_valid && bus.out_ready;
    assign level_d = (OCC_W+1)'(occ) - (OCC_W+1)'(pop) + (OCC_W+1)'(inflight_q);
    assign credit  = level_d < (OCC_W+1)'(DEPTH);
    assign bus.fifo_rd_en = rd_rst_n && !bus.fifo_rd_empty && credit;

    assign push     = inflight_q && (state_q == PAY);
    assign push_ent = {type_q, first_q, rem_q == LEN_W'(1), bus.fifo_rd_data};
    assign err_hit  = inflight_q && (state_q == HDR) &&
                      ((hdr_len == '0) || (hdr_len > MAX_LEN_L));

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q    <= HDR;
            rem_q      <= '0;
            type_q     <= '0;
            first_q    <= 1'b0;
            inflight_q <= 1'b0;
            msg_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            inflight_q <= bus.fifo_rd_en;
            if (inflight_q) begin
                unique case (state_q)
                    HDR: begin
                        if (hdr_len > MAX_LEN_L) begin
                            rem_q   <= hdr_len;
                            state_q <= DROP;
                        end else if (hdr_len != '0) begin
                            type_q  <= hdr_type;
                            rem_q   <= hdr_len;
                            first_q <= 1'b1;
                            state_q <= PAY;
                        end
                    end
                    PAY: begin
                        first_q <= 1'b0;
                        rem_q   <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_q <= HDR;
                    end
                    DROP: begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state_q <= HDR;
                    end
                    default: state_q <= HDR;
                endcase
            end
            if (pop && bus.out_eop && (msg_cnt_q != '1)) msg_cnt_q <= msg_cnt_q + CNT_W'(1);
            if (err_hit && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    hft_stream_fifo_buf #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i       (rd_clk),
        .rst_ni      (rd_rst_n),
        .push_i      (push),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .head_o      (head_ent),
        .occ_o       (occ)
    );

    assign bus.out_valid = (occ != '0);
    assign {bus.out_type, bus.out_sop, bus.out_eop, bus.out_data} = head_ent;
    assign msg_cnt = msg_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_fifo_msg_deframer.sv
// Scoreboard bench: frames are generated at message level, expected beats queued, monitor compares.
module tb_fifo_msg_deframer;
    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned CNT_W   = 8;   // narrow counters so saturation is reachable quickly
    localparam int SAT = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]  typ;
        logic        sop;
        logic        eop;
        logic [15:0] data;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [CNT_W-1:0] msg_cnt;
    logic [CNT_W-1:0] err_cnt;

    fifo_msg_deframer_if #(.DATA_W(16)) bus ();

    fifo_msg_deframer #(
        .DATA_W  (16),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .rd_clk   (clk),
        .rd_rst_n (rst_n),
        .bus      (bus),
        .msg_cnt  (msg_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] src_q[$];
    beat_t       exp_q[$];
    int          pop_cyc[$];
    int          beat_cyc[$];
    int cyc             = 0;
    int bubble_pct      = 0;
    int ready_mode      = 1;
    int checks          = 0;
    int errors          = 0;
    int good_msgs       = 0;
    int bad_hdrs        = 0;
    int first_valid_cyc = -1;

    // FIFO read-port model: data appears the cycle after an accepted pop.
    always @(posedge clk) begin
        if (bus.fifo_rd_en && src_q.size() != 0) begin
            bus.fifo_rd_data <= src_q.pop_front();
            pop_cyc.push_back(cyc);
        end
        cyc++;
        bus.fifo_rd_empty <= (src_q.size() == 0) || ($urandom_range(99) < bubble_pct);
    end

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(1));
        endcase
    end

    beat_t prev_beat;
    logic  stall_q = 1'b0;

    always @(negedge clk) begin
        beat_t act;
        beat_t e;
        act = {bus.out_type, bus.out_sop, bus.out_eop, bus.out_data};
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (bus.fifo_rd_en && src_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fifo_overrun rd_en=1 with FIFO empty, required rd_en=0");
            end
            if (stall_q) begin
                checks++;
                if (!bus.out_valid || act !== prev_beat) begin
                    errors++;
                    $display("FAIL axis_hold valid=%0b beat=%h required valid=1 beat=%h",
                             bus.out_valid, act, prev_beat);
                end
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                beat_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got=%h required=no beat", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL beat got type=%h sop=%0b eop=%0b data=%h required type=%h sop=%0b eop=%0b data=%h",
                                 act.typ, act.sop, act.eop, act.data, e.typ, e.sop, e.eop, e.data);
                    end
                end
            end
            stall_q   = bus.out_valid && !bus.out_ready;
            prev_beat = act;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_msg_cnt"}, int'(msg_cnt), (good_msgs > SAT) ? SAT : good_msgs);
        check({tag, "_err_cnt"}, int'(err_cnt), (bad_hdrs > SAT) ? SAT : bad_hdrs);
    endtask

    // A frame is a header {type,len} plus len words; only legal lengths produce beats.
    task automatic frame(input logic [3:0] typ, input int len, input logic [15:0] base, input bit rnd);
        logic [15:0] w;
        src_q.push_back({typ, 12'(len)});
        for (int i = 0; i < len; i++) begin
            w = rnd ? 16'($urandom) : base + 16'(i);
            src_q.push_back(w);
            if (len <= int'(MAX_LEN)) exp_q.push_back({typ, i == 0, i == len - 1, w});
        end
        if (len == 0 || len > int'(MAX_LEN)) bad_hdrs++;
        else good_msgs++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout pending_beats=%0d pending_words=%0d required 0/0",
                     exp_q.size(), src_q.size());
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int base;
        int sel;
        int len;

        repeat (3) @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_sop",   bus.out_sop, 0);
        check("rst_eop",   bus.out_eop, 0);
        check("rst_data",  bus.out_data, 0);
        check("rst_type",  bus.out_type, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_msg",   msg_cnt, 0);
        check("rst_err",   err_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single 3-word frame and pop-to-valid latency
        base = pop_cyc.size();
        first_valid_cyc = -1;
        frame(4'h1, 3, 16'hA001, 1'b0);
        wait_idle();
        check("t1_latency", first_valid_cyc - pop_cyc[base+1], 2);
        check_counts("t1");

        // back-to-back frames: only the header slot may separate beats
        beat_cyc.delete();
        frame(4'h2, 2, 16'hB000, 1'b0);
        frame(4'h3, 1, 16'hC000, 1'b0);
        wait_idle();
        check("t2_beats", beat_cyc.size(), 3);
        check("t2_gap_in_frame", beat_cyc[1] - beat_cyc[0], 1);
        check("t2_gap_hdr_slot", beat_cyc[2] - beat_cyc[1], 2);
        check_counts("t2");

        // zero length and over-long frames are dropped
        frame(4'h1, 0, 16'h0000, 1'b0);
        frame(4'h4, 33, 16'h4400, 1'b0);
        frame(4'h5, 1, 16'hD000, 1'b0);
        wait_idle();
        check_counts("t3");

        // back-pressure: header + 4 payload words fit, then pops stop
        ready_mode = 0;
        repeat (2) @(negedge clk);
        base = pop_cyc.size();
        frame(4'h6, 8, 16'h8000, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_pops_stalled", pop_cyc.size() - base, 5);
        check("t4_rd_en_low", bus.fifo_rd_en, 0);
        check("t4_valid_held", bus.out_valid, 1);
        ready_mode = 1;
        wait_idle();
        check_counts("t4");

        // randomized traffic with FIFO bubbles and random ready
        bubble_pct = 30;
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(9);
            case (sel)
                0:       len = 0;
                1:       len = int'(MAX_LEN) + 1 + $urandom_range(7);
                2:       len = int'(MAX_LEN);
                3:       len = 1;
                default: len = $urandom_range(8, 1);
            endcase
            frame(4'($urandom), len, 16'h0, 1'b1);
            if (k == 20) frame(4'h9, 4095, 16'h0, 1'b1);
        end
        wait_idle();
        bubble_pct = 0;
        ready_mode = 1;
        repeat (4) @(negedge clk);
        check_counts("rand");

        // asynchronous reset in the middle of a 5-word frame
        src_q.push_back(16'h1005);
        src_q.push_back(16'h5500);
        src_q.push_back(16'h5501);
        exp_q.push_back({4'h1, 1'b1, 1'b0, 16'h5500});
        exp_q.push_back({4'h1, 1'b0, 1'b0, 16'h5501});
        wait_idle();
        @(negedge clk);
        src_q.push_back(16'h5502);
        src_q.push_back(16'h5503);
        src_q.push_back(16'h5504);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", bus.out_valid, 0);
        check("t5_sop",   bus.out_sop, 0);
        check("t5_eop",   bus.out_eop, 0);
        check("t5_data",  bus.out_data, 0);
        check("t5_type",  bus.out_type, 0);
        check("t5_msg",   msg_cnt, 0);
        check("t5_err",   err_cnt, 0);
        @(posedge clk);
        #1 check("t5_rd_en_in_reset", bus.fifo_rd_en, 0);
        src_q.delete();
        good_msgs = 0;
        bad_hdrs  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frame(4'h2, 1, 16'hE000, 1'b0);
        wait_idle();
        check_counts("t5_after");

        // counter saturation
        for (int k = 0; k < 250; k++) frame(4'h7, 0, 16'h0, 1'b0);
        wait_idle();
        check_counts("t6_pre");
        for (int k = 0; k < 10; k++) frame(4'h7, 0, 16'h0, 1'b0);
        for (int k = 0; k < 260; k++) frame(4'h1, 1, 16'h0, 1'b1);
        wait_idle();
        check_counts("t6_sat");
        check("t6_err_all_ones", err_cnt, SAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
